// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, branch squashes and data memory wait/timeout.
// Optional macro PIPE_STALL_PERF_EN adds a saturating stall-cycle performance counter.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ex_branch_taken,
  input  logic        exmem_mem_access,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic        mem_err,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt, wait_cnt_inc;
  logic             freeze, load_use;

  assign freeze   = exmem_mem_access & ~dmem_ack;
  assign load_use = idex_mem_read & (idex_rt != 5'd0) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
  // The first frozen cycle in RUN counts as wait cycle 1.
  assign wait_cnt_inc = (state == RUN) ? CNT_W'(1) : wait_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    dmem_req     = 1'b0;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (state == ERR) begin
      memwb_bubble = 1'b1;
    end else begin
      dmem_req = exmem_mem_access;
      if (freeze) begin
        memwb_bubble = 1'b1;
        wait_cnt_nxt = wait_cnt_inc;
        // An ack arriving on the TIMEOUT-th wait cycle clears freeze, so it beats the watchdog.
        state_nxt    = (wait_cnt_inc == CNT_W'(TIMEOUT)) ? ERR : MEM_WAIT;
      end else begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
        if (ex_branch_taken) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
        end
      end
    end
    // Reset forces the pipe quiet immediately, without waiting for a clock edge.
    if (reset) begin
      dmem_req     = 1'b0;
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
    end
  end

  assign mem_err = (state == ERR);

`ifdef PIPE_STALL_PERF_EN
  logic [15:0] stall_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       stall_cnt <= '0;
    else if (!pc_en) stall_cnt <= sat_inc16(stall_cnt);
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, branch squash, memory wait, watchdog and reset.
// Control outputs are packed as {dmem_req,pc_en,ifid_en,idex_en,exmem_en,ifid_flush,idex_flush,memwb_bubble}.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        idex_mem_read, ex_branch_taken, exmem_mem_access, dmem_ack;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        dmem_req, pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [15:0] stall_cycles;
  logic [7:0]  ctl;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [7:0] C_NORM   = 8'b0111_1000;
  localparam logic [7:0] C_LDUSE  = 8'b0001_1010;
  localparam logic [7:0] C_BRANCH = 8'b0111_1110;
  localparam logic [7:0] C_FREEZE = 8'b1000_0001;
  localparam logic [7:0] C_ACKED  = 8'b1111_1000;
  localparam logic [7:0] C_ERR    = 8'b0000_0001;
`ifdef PIPE_STALL_PERF_EN
  localparam logic [15:0] EXP_STALL4 = 16'd4;
`else
  localparam logic [15:0] EXP_STALL4 = 16'd0;
`endif

  pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ex_branch_taken(ex_branch_taken), .exmem_mem_access(exmem_mem_access),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign ctl = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                       input logic [4:0] id_rt, input logic br, input logic acc, input logic ack);
    idex_mem_read    = mr;
    idex_rt          = rt;
    ifid_rs          = rs;
    ifid_rt          = id_rt;
    ex_branch_taken  = br;
    exmem_mem_access = acc;
    dmem_ack         = ack;
  endtask

  // Check the combinational controls mid-cycle, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, {24'd0, ctl}, {24'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    check("reset_ctl", {24'd0, ctl}, 32'd0);
    check("reset_err", {31'd0, mem_err}, 32'd0);
    check("reset_stall", {16'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    cyc("normal", C_NORM);
    drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    cyc("loaduse_rs", C_LDUSE);
    drive(1'b0, 5'd0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    cyc("after_loaduse", C_NORM);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("load_r0", C_NORM);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("branch_over_hazard", C_BRANCH);

    // Three frozen cycles with a hazard present (ignored), released on the ack cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
      cyc("freeze3", C_FREEZE);
    end
    check("stall_perf", {16'd0, stall_cycles}, {16'd0, EXP_STALL4});
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("ack_release", C_ACKED);
    drive(1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc("loaduse_rt", C_LDUSE);

    // Ack on the 16th wait cycle must beat the watchdog.
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      cyc("wait15", C_FREEZE);
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("ack_at_16", C_ACKED);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("after_ack16", C_NORM);
    check("no_err_at_16", {31'd0, mem_err}, 32'd0);

    // No ack for 16 wait cycles: sticky error.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      cyc("wait16", C_FREEZE);
    end
    check("err_set", {31'd0, mem_err}, 32'd1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("err_ack_ignored", C_ERR);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("err_branch_ignored", C_ERR);
    check("err_sticky", {31'd0, mem_err}, 32'd1);

    // Asynchronous reset out of ERR.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_ctl", {24'd0, ctl}, 32'd0);
    check("async_reset_err", {31'd0, mem_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cyc("run_after_reset", C_NORM);

    // Reset mid-wait drops dmem_req immediately.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("midwait1", C_FREEZE);
    cyc("midwait2", C_FREEZE);
    #1;
    reset = 1'b1;
    #1;
    check("midwait_req_drop", {31'd0, dmem_req}, 32'd0);
    check("midwait_stall_clr", {16'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cyc("run_after_midwait", C_NORM);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("zero_wait", C_ACKED);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("after_zero_wait", C_NORM);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
